blob_locator: RTL and testbench

- Inverse of the sprite renderer: instead of painting a colored rectangle at (x,y), it watches the camera pixel stream with its hcount/vcount and finds the rectangle of pixels matching a target color.
- Per frame it reports:
  - bounding box of matching pixels;
  - box center (blob_x, blob_y);
  - matching-pixel count;
  - found flag.
- Sits between the video capture path and the gesture/drone control logic.

---
 rtl/blob_locator.sv | 167 ++++++++++++++++
 tb/tb_blob_locator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_locator.sv
// blob_locator
//   Watches the camera pixel stream and, once per frame, reports the bounding
//   box, centre and pixel count of all pixels whose colour lies within
//   'tolerance' (per channel) of 'target_color'.
//
// Ports:
//   clk            pixel clock
//   reset          synchronous, active-high reset
//   hcount/vcount  raster position of pixel_in
//   pixel_in       RGB 8:8:8, R in [23:16]
//   target_color   RGB colour to track
//   tolerance      max per-channel absolute difference (0 = exact match)
//   blob_x/blob_y  centre of the bounding box of the last found blob
//   box_*          bounding box of the last found blob
//   pix_count      matching pixels in the last frame
//   found          pix_count >= MIN_PIXELS for the last frame
//   frame_done     one-cycle strobe, coincident with updated outputs
module blob_locator #(
    parameter int H_ACTIVE   = 1024,
    parameter int V_ACTIVE   = 768,
    parameter int MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [23:0] pixel_in,
    input  logic [23:0] target_color,
    input  logic [7:0]  tolerance,
    output logic [10:0] blob_x,
    output logic [9:0]  blob_y,
    output logic [10:0] box_xmin,
    output logic [10:0] box_xmax,
    output logic [9:0]  box_ymin,
    output logic [9:0]  box_ymax,
    output logic [19:0] pix_count,
    output logic        found,
    output logic        frame_done
);

    localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM   = 10'(V_ACTIVE);
    localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

    localparam logic [10:0] XMIN_INIT = 11'd2047;
    localparam logic [9:0]  YMIN_INIT = 10'd1023;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ACCUM,
        REPORT
    } state_t;

    state_t state, next_state;

    logic        match_c;
    logic        frame_start;
    logic        frame_end;
    logic        match_q;
    logic [10:0] hc_q;
    logic [9:0]  vc_q;

    logic [10:0] xmin, xmax;
    logic [9:0]  ymin, ymax;
    logic [19:0] cnt;

    logic        cnt_found;
    logic [11:0] x_sum;
    logic [10:0] y_sum;

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        match_c = (absdiff(pixel_in[23:16], target_color[23:16]) <= tolerance) &&
                  (absdiff(pixel_in[15:8],  target_color[15:8])  <= tolerance) &&
                  (absdiff(pixel_in[7:0],   target_color[7:0])   <= tolerance) &&
                  (hcount < H_LIM) && (vcount < V_LIM);
        frame_start = (hcount == '0) && (vcount == '0);
        frame_end   = (hcount == '0) && (vcount == V_LIM);
        cnt_found   = (cnt >= MIN_CNT);
        x_sum       = {1'b0, xmin} + {1'b0, xmax};
        y_sum       = {1'b0, ymin} + {1'b0, ymax};
    end

    // Stage 1: colour/position match and registered coordinates
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
            hc_q    <= '0;
            vc_q    <= '0;
        end else begin
            match_q <= match_c;
            hc_q    <= hcount;
            vc_q    <= vcount;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_FRAME;
        end else begin
            state <= next_state;
        end
    end

    // Frame boundaries are decoded on the raw input side; the two-stage
    // pipeline has drained by the time the frame-end position appears.
    always_comb begin
        next_state = state;
        case (state)
            WAIT_FRAME: if (frame_start) next_state = ACCUM;
            ACCUM:      if (frame_end)   next_state = REPORT;
            REPORT:     next_state = ACCUM;
            default:    next_state = WAIT_FRAME;
        endcase
    end

    // Stage 2: bounding-box and count accumulators
    always_ff @(posedge clk) begin
        if (reset || state != ACCUM) begin
            xmin <= XMIN_INIT;
            xmax <= '0;
            ymin <= YMIN_INIT;
            ymax <= '0;
            cnt  <= '0;
        end else if (match_q) begin
            if (hc_q < xmin) xmin <= hc_q;
            if (hc_q > xmax) xmax <= hc_q;
            if (vc_q < ymin) ymin <= vc_q;
            if (vc_q > ymax) ymax <= vc_q;
            if (cnt != '1)   cnt  <= cnt + 20'd1;
        end
    end

    // Result registers: loaded only at the end of REPORT, so frame_done
    // rises together with the new values. Box/centre hold when not found.
    always_ff @(posedge clk) begin
        if (reset) begin
            blob_x     <= '0;
            blob_y     <= '0;
            box_xmin   <= '0;
            box_xmax   <= '0;
            box_ymin   <= '0;
            box_ymax   <= '0;
            pix_count  <= '0;
            found      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == REPORT);
            if (state == REPORT) begin
                pix_count <= cnt;
                found     <= cnt_found;
                if (cnt_found) begin
                    box_xmin <= xmin;
                    box_xmax <= xmax;
                    box_ymin <= ymin;
                    box_ymax <= ymax;
                    blob_x   <= x_sum[11:1];
                    blob_y   <= y_sum[10:1];
                end
            end
        end
    end

endmodule

// File: tb/tb_blob_locator.sv
// tb_blob_locator
//   Drives sparse raster streams into two blob_locator instances (default
//   MIN_PIXELS and MIN_PIXELS=2) and compares their per-frame reports with a
//   list-based reference model of the frame contents.
module tb_blob_locator;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [23:0] pixel_in;
    logic [23:0] target_color;
    logic [7:0]  tolerance;

    logic [10:0] a_bx, a_xmin, a_xmax, b_bx, b_xmin, b_xmax;
    logic [9:0]  a_by, a_ymin, a_ymax, b_by, b_ymin, b_ymax;
    logic [19:0] a_cnt, b_cnt;
    logic        a_found, b_found, a_fd, b_fd;

    typedef struct packed {
        logic [10:0] bx;
        logic [9:0]  by;
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [9:0]  ymin;
        logic [9:0]  ymax;
        logic [19:0] cnt;
        logic        found;
    } res_t;

    res_t obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {a_bx, a_by, a_xmin, a_xmax, a_ymin, a_ymax, a_cnt, a_found};
    assign obs_b = {b_bx, b_by, b_xmin, b_xmax, b_ymin, b_ymax, b_cnt, b_found};

    always #5 clk = ~clk;

    blob_locator dut_a (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .pixel_in(pixel_in), .target_color(target_color), .tolerance(tolerance),
        .blob_x(a_bx), .blob_y(a_by), .box_xmin(a_xmin), .box_xmax(a_xmax),
        .box_ymin(a_ymin), .box_ymax(a_ymax), .pix_count(a_cnt),
        .found(a_found), .frame_done(a_fd)
    );

    blob_locator #(.MIN_PIXELS(2)) dut_b (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .pixel_in(pixel_in), .target_color(target_color), .tolerance(tolerance),
        .blob_x(b_bx), .blob_y(b_by), .box_xmin(b_xmin), .box_xmax(b_xmax),
        .box_ymin(b_ymin), .box_ymax(b_ymax), .pix_count(b_cnt),
        .found(b_found), .frame_done(b_fd)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is tracked once a pixel at (0,0) has been seen
    // since reset; matching coordinates of the current frame are listed.
    bit armed;
    int mh[$];
    int mv[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit ref_match(int h, int v, logic [23:0] c);
        int d;
        if (h >= 1024 || v >= 768) return 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            d = int'(c[ch*8 +: 8]) - int'(target_color[ch*8 +: 8]);
            if (d < 0) d = -d;
            if (d > int'(tolerance)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic res_t next_res(res_t prev, int min_p);
        res_t r = prev;
        int xmn = 2047, xmx = 0, ymn = 1023, ymx = 0;
        r.cnt   = 20'(mh.size());
        r.found = (mh.size() >= min_p);
        if (r.found) begin
            foreach (mh[i]) begin
                if (mh[i] < xmn) xmn = mh[i];
                if (mh[i] > xmx) xmx = mh[i];
                if (mv[i] < ymn) ymn = mv[i];
                if (mv[i] > ymx) ymx = mv[i];
            end
            r.xmin = 11'(xmn);
            r.xmax = 11'(xmx);
            r.ymin = 10'(ymn);
            r.ymax = 10'(ymx);
            r.bx   = 11'((xmn + xmx) / 2);
            r.by   = 10'((ymn + ymx) / 2);
        end
        return r;
    endfunction

    task automatic pix(input int h, input int v, input logic [23:0] c);
        hcount   = 11'(h);
        vcount   = 10'(v);
        pixel_in = c;
        if (!reset) begin
            if (!armed && h == 0 && v == 0) armed = 1'b1;
            if (armed && ref_match(h, v, c)) begin
                mh.push_back(h);
                mv.push_back(v);
            end
        end
        @(negedge clk);
    endtask

    task automatic end_frame(input string tag);
        res_t prev_a = exp_a;
        res_t prev_b = exp_b;
        bit expect_pulse = armed;
        if (expect_pulse) begin
            exp_a = next_res(exp_a, 64);
            exp_b = next_res(exp_b, 2);
            mh.delete();
            mv.delete();
        end
        hcount   = 11'd0;
        vcount   = 10'd768;
        pixel_in = '0;
        @(negedge clk);
        chk({tag, "_hold_a"}, obs_a, prev_a);
        chk({tag, "_hold_b"}, obs_b, prev_b);
        chk({tag, "_fd_early"}, a_fd, 1'b0);
        hcount = 11'd1;
        vcount = 10'd769;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_fd_a"}, a_fd, expect_pulse && i == 0);
            chk({tag, "_fd_b"}, b_fd, expect_pulse && i == 0);
            chk({tag, "_res_a"}, obs_a, exp_a);
            chk({tag, "_res_b"}, obs_b, exp_b);
        end
    endtask

    task automatic model_reset();
        armed = 1'b0;
        mh.delete();
        mv.delete();
        exp_a = '0;
        exp_b = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_zero_a"}, obs_a, 0);
        chk({tag, "_zero_b"}, obs_b, 0);
        chk({tag, "_zero_fd"}, {a_fd, b_fd}, 0);
    endtask

    task automatic patch_frame(input string tag);
        target_color = 24'h20C040;
        tolerance    = 8'd0;
        pix(0, 0, 24'h000000);
        for (int y = 50; y <= 59; y++)
            for (int x = 98; x <= 111; x++)
                pix(x, y, (x >= 100 && x <= 109) ? 24'h20C040 : 24'h000000);
        pix(300, 300, 24'h000000);
        end_frame(tag);
    endtask

    function automatic logic [23:0] near_color();
        logic [23:0] c;
        for (int ch = 0; ch < 3; ch++)
            c[ch*8 +: 8] = target_color[ch*8 +: 8] + 8'($urandom_range(0, 40)) - 8'd20;
        return c;
    endfunction

    initial begin
        reset        = 1'b1;
        hcount       = 11'd5;
        vcount       = 10'd770;
        pixel_in     = '0;
        target_color = '0;
        tolerance    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // 10x10 exact-colour patch
        patch_frame("patch");
        chk("patch_cnt",   a_cnt, 20'd100);
        chk("patch_found", a_found, 1'b1);
        chk("patch_box",   {a_xmin, a_xmax, a_ymin, a_ymax}, {11'd100, 11'd109, 10'd50, 10'd59});
        chk("patch_ctr",   {a_bx, a_by}, {11'd104, 10'd54});

        // 20 matches: below MIN_PIXELS on dut_a, box/centre held
        pix(0, 0, 24'h000000);
        for (int x = 200; x < 220; x++) pix(x, 10, 24'h20C040);
        end_frame("small");
        chk("small_cnt",   a_cnt, 20'd20);
        chk("small_found", a_found, 1'b0);
        chk("small_ctr",   {a_bx, a_by}, {11'd104, 10'd54});
        chk("small_b_ctr", {b_bx, b_by}, {11'd209, 10'd10});

        // tolerance edges
        target_color = 24'h808080;
        tolerance    = 8'd4;
        pix(0, 0, 24'h000000);
        pix(5, 5, 24'h848080);
        pix(6, 5, 24'h858080);
        pix(7, 5, 24'h7C7C7C);
        end_frame("tol");
        chk("tol_cnt", a_cnt, 20'd2);
        chk("tol_b_box", {b_xmin, b_xmax}, {11'd5, 11'd7});

        // opposite corners of the active area
        target_color = 24'h123456;
        tolerance    = 8'd0;
        pix(0, 0, 24'h123456);
        pix(500, 400, 24'h123457);
        pix(1023, 767, 24'h123456);
        end_frame("corner");
        chk("corner_box", {b_xmin, b_xmax, b_ymin, b_ymax}, {11'd0, 11'd1023, 10'd0, 10'd767});
        chk("corner_ctr", {b_bx, b_by}, {11'd511, 10'd383});
        chk("corner_found_a", a_found, 1'b0);

        // matching colour outside the active area
        pix(0, 0, 24'h000000);
        pix(1100, 10, 24'h123456);
        pix(10, 800, 24'h123456);
        pix(1024, 0, 24'h123456);
        end_frame("offscreen");
        chk("offscreen_cnt",   b_cnt, 20'd0);
        chk("offscreen_found", b_found, 1'b0);

        // reset in the middle of a frame
        pix(0, 0, 24'h123456);
        for (int y = 100; y < 300; y += 20) pix(40, y, 24'h123456);
        reset = 1'b1;
        model_reset();
        pix(20, 300, 24'h123456);
        chk_zero("midrst_a");
        pix(21, 300, 24'h123456);
        chk_zero("midrst_b");
        reset = 1'b0;
        for (int y = 301; y < 311; y++) pix(30, y, 24'h123456);
        chk_zero("midrst_after");
        end_frame("midrst_frame");
        chk_zero("midrst_nofd");
        patch_frame("postrst");
        chk("postrst_cnt", a_cnt, 20'd100);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            int h, v;
            target_color = $urandom;
            tolerance    = 8'($urandom_range(0, 20));
            pix(0, 0, near_color());
            repeat (150) begin
                h = $urandom_range(0, 1100);
                v = $urandom_range(1, 800);
                if (v == 768) v = 769;
                pix(h, v, near_color());
            end
            end_frame("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
